// File: rtl/boot_reset_seq.sv
// boot_reset_seq: holds staged resets until required downloads are loaded and all
// reset requests clear, then releases each stage in order after a hold count.
module boot_reset_seq #(
    parameter int                NSRC        = 3,
    parameter int                HOLD_W      = 16,
    parameter logic [HOLD_W-1:0] HOLD        = 16'hFFFF,
    parameter logic [63:0]       REQ_MASK    = 64'h1,
    parameter logic [63:0]       DLHOLD_MASK = 64'h1,
    parameter int                UNLOAD_IDX  = 1,
    parameter int                NSTAGE      = 2,
    parameter int                STAGE_GAP   = 256
) (
    input  logic              clk_i,
    input  logic              res_n_i,
    input  logic [NSRC-1:0]   rst_req_i,
    input  logic              dl_active_i,
    input  logic [5:0]        dl_index_i,
    input  logic              unload_i,
    output logic [NSTAGE-1:0] rst_o,
    output logic              ready_o,
    output logic [63:0]       loaded_o,
    output logic [1:0]        state_o
);
    localparam int IDX_W = NSTAGE > 1 ? $clog2(NSTAGE) : 1;
    localparam int GAP_W = STAGE_GAP > 1 ? $clog2(STAGE_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_RLD = GAP_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NSTAGE - 1);

    typedef enum logic [1:0] {S_WAIT, S_HOLD, S_STAGE, S_RUN} state_t;

    state_t            state_q, state_n;
    logic [HOLD_W-1:0] hold_q, hold_n;
    logic [IDX_W-1:0]  idx_q, idx_n;
    logic [GAP_W-1:0]  gap_q, gap_n;
    logic [NSTAGE-1:0] rst_q, rst_n;
    logic              ready_q, ready_n;
    logic [63:0]       loaded_q, loaded_n;
    logic              dl_d;
    logic [5:0]        idx_lat;
    logic              force_rst;

    assign force_rst = |rst_req_i || |(REQ_MASK & ~loaded_q) || (dl_active_i && DLHOLD_MASK[dl_index_i]);

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            state_q  <= S_WAIT;
            hold_q   <= HOLD;
            idx_q    <= '0;
            gap_q    <= '0;
            rst_q    <= '1;
            ready_q  <= 1'b0;
            loaded_q <= '0;
            dl_d     <= 1'b0;
            idx_lat  <= '0;
        end else begin
            state_q  <= state_n;
            hold_q   <= hold_n;
            idx_q    <= idx_n;
            gap_q    <= gap_n;
            rst_q    <= rst_n;
            ready_q  <= ready_n;
            loaded_q <= loaded_n;
            dl_d     <= dl_active_i;
            if (dl_active_i && !dl_d)
                idx_lat <= dl_index_i;
        end
    end

    // Unload is applied last so it wins over a completion on the same index.
    always_comb begin
        loaded_n = loaded_q;
        if (!dl_active_i && dl_d)
            loaded_n[idx_lat] = 1'b1;
        if (unload_i)
            loaded_n[UNLOAD_IDX] = 1'b0;
    end

    always_comb begin
        state_n = state_q;
        hold_n  = hold_q;
        idx_n   = idx_q;
        gap_n   = gap_q;
        rst_n   = rst_q;
        ready_n = ready_q;
        if (force_rst) begin
            state_n = S_WAIT;
            hold_n  = HOLD;
            rst_n   = '1;
            ready_n = 1'b0;
        end else begin
            case (state_q)
                S_WAIT: begin
                    state_n = S_HOLD;
                    hold_n  = HOLD;
                end
                S_HOLD: begin
                    if (hold_q != '0) begin
                        hold_n = hold_q - HOLD_W'(1);
                    end else begin
                        rst_n[0] = 1'b0;
                        if (NSTAGE == 1) begin
                            state_n = S_RUN;
                            ready_n = 1'b1;
                        end else begin
                            state_n = S_STAGE;
                            idx_n   = IDX_W'(1);
                            gap_n   = GAP_RLD;
                        end
                    end
                end
                S_STAGE: begin
                    if (gap_q != '0) begin
                        gap_n = gap_q - GAP_W'(1);
                    end else begin
                        rst_n[idx_q] = 1'b0;
                        if (idx_q == LAST) begin
                            state_n = S_RUN;
                            ready_n = 1'b1;
                        end else begin
                            idx_n = idx_q + IDX_W'(1);
                            gap_n = GAP_RLD;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rst_o    = rst_q;
    assign ready_o  = ready_q;
    assign loaded_o = loaded_q;
    assign state_o  = state_q;
endmodule

// File: tb/tb_boot_reset_seq.sv
// tb_boot_reset_seq: directed stimulus pushes expected snapshots keyed by edge count;
// a negedge monitor pops and compares them against the DUT.
module tb_boot_reset_seq;
    logic        clk_i = 1'b0;
    logic        res_n_i = 1'b0;
    logic [2:0]  rst_req_i = '0;
    logic        dl_active_i = 1'b0;
    logic [5:0]  dl_index_i = '0;
    logic        unload_i = 1'b0;
    logic [1:0]  rst_o;
    logic        ready_o;
    logic [63:0] loaded_o;
    logic [1:0]  state_o;

    boot_reset_seq #(
        .NSRC(3), .HOLD_W(16), .HOLD(16'd4), .REQ_MASK(64'h1), .DLHOLD_MASK(64'h1),
        .UNLOAD_IDX(1), .NSTAGE(2), .STAGE_GAP(3)
    ) dut (
        .clk_i(clk_i), .res_n_i(res_n_i), .rst_req_i(rst_req_i), .dl_active_i(dl_active_i),
        .dl_index_i(dl_index_i), .unload_i(unload_i), .rst_o(rst_o), .ready_o(ready_o),
        .loaded_o(loaded_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        int         k;
        logic [1:0] rst;
        logic       rdy;
        logic [1:0] st;
        logic [1:0] ld;
    } exp_t;

    exp_t  sb[$];
    string nq[$];
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    exp_t  me;
    string mn;

    always @(posedge clk_i) cyc <= cyc + 1;

    // cyc counts edges seen; an entry with k==cyc is compared at the following negedge.
    always @(negedge clk_i) begin
        while (sb.size() > 0 && sb[0].k <= cyc) begin
            me = sb.pop_front();
            mn = nq.pop_front();
            checks++;
            if (me.k != cyc || rst_o !== me.rst || ready_o !== me.rdy || state_o !== me.st ||
                loaded_o[1:0] !== me.ld || loaded_o[63:2] !== '0) begin
                errors++;
                $display("FAIL %s @edge %0d (want edge %0d): got rst=%b rdy=%b st=%0d ld=%h, want rst=%b rdy=%b st=%0d ld=%b",
                         mn, cyc, me.k, rst_o, ready_o, state_o, loaded_o, me.rst, me.rdy, me.st, me.ld);
            end
        end
    end

    task automatic push(input int k, input string nm, input logic [1:0] rst, input logic rdy,
                        input logic [1:0] st, input logic [1:0] ld);
        exp_t e;
        e.k = k; e.rst = rst; e.rdy = rdy; e.st = st; e.ld = ld;
        sb.push_back(e);
        nq.push_back(nm);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_to(input int k);
        while (cyc < k) tick();
    endtask

    // e is the WAIT->HOLD edge: rst_o[0] falls at e+5, rst_o[1]/ready_o at e+8.
    task automatic seq_expect(input int e, input logic [1:0] ld, input string tag);
        push(e,     {tag, "_hold"},   2'b11, 1'b0, 2'd1, ld);
        push(e + 4, {tag, "_hold0"},  2'b11, 1'b0, 2'd1, ld);
        push(e + 5, {tag, "_stage"},  2'b10, 1'b0, 2'd2, ld);
        push(e + 7, {tag, "_gap0"},   2'b10, 1'b0, 2'd2, ld);
        push(e + 8, {tag, "_run"},    2'b00, 1'b1, 2'd3, ld);
    endtask

    initial begin
        int c, d, e;
        ticks(2);
        push(cyc, "reset", 2'b11, 1'b0, 2'd0, 2'b00);
        res_n_i = 1'b1;
        c = cyc;
        for (int i = 1; i <= 8; i++) push(c + i, "no_dl", 2'b11, 1'b0, 2'd0, 2'b00);
        ticks(8);

        dl_active_i = 1'b1; dl_index_i = 6'd0; c = cyc;
        push(c + 5, "dl_busy", 2'b11, 1'b0, 2'd0, 2'b00);
        ticks(10);
        dl_active_i = 1'b0; d = cyc;
        push(d + 1, "dl_done", 2'b11, 1'b0, 2'd0, 2'b01);
        seq_expect(d + 2, 2'b01, "boot");
        run_to(d + 10);
        push(cyc, "run_hold", 2'b00, 1'b1, 2'd3, 2'b01);

        rst_req_i = 3'b010; tick(); rst_req_i = 3'b000; d = cyc;
        push(d, "req_pulse", 2'b11, 1'b0, 2'd0, 2'b01);
        seq_expect(d + 1, 2'b01, "reseq");
        run_to(d + 9);

        dl_active_i = 1'b1; dl_index_i = 6'd1; c = cyc;
        push(c + 2, "dl1_busy", 2'b00, 1'b1, 2'd3, 2'b01);
        ticks(3);
        dl_active_i = 1'b0; d = cyc;
        push(d + 1, "dl1_done", 2'b00, 1'b1, 2'd3, 2'b11);
        tick();
        unload_i = 1'b1;
        push(d + 2, "unload", 2'b00, 1'b1, 2'd3, 2'b01);
        tick();
        dl_active_i = 1'b1;
        ticks(2);
        dl_active_i = 1'b0; e = cyc;
        push(e + 1, "unload_wins", 2'b00, 1'b1, 2'd3, 2'b01);
        tick();
        unload_i = 1'b0;
        tick();
        push(cyc, "run_after_unload", 2'b00, 1'b1, 2'd3, 2'b01);

        rst_req_i = 3'b100; tick(); rst_req_i = 3'b000; d = cyc;
        push(d, "req2", 2'b11, 1'b0, 2'd0, 2'b01);
        push(d + 1, "hold5", 2'b11, 1'b0, 2'd1, 2'b01);
        push(d + 6, "stage5", 2'b10, 1'b0, 2'd2, 2'b01);
        run_to(d + 6);
        rst_req_i = 3'b001;
        push(d + 7, "stage_abort", 2'b11, 1'b0, 2'd0, 2'b01);
        push(d + 8, "abort_wait", 2'b11, 1'b0, 2'd0, 2'b01);
        ticks(2);
        rst_req_i = 3'b000;
        seq_expect(d + 9, 2'b01, "abort");
        run_to(d + 17);

        rst_req_i = 3'b001; tick(); rst_req_i = 3'b000; d = cyc;
        push(d, "req0", 2'b11, 1'b0, 2'd0, 2'b01);
        push(d + 1, "hold6", 2'b11, 1'b0, 2'd1, 2'b01);
        push(d + 3, "async_rst", 2'b11, 1'b0, 2'd0, 2'b00);
        push(d + 4, "in_rst", 2'b11, 1'b0, 2'd0, 2'b00);
        run_to(d + 3);
        #2 res_n_i = 1'b0;
        tick();
        res_n_i = 1'b1;
        push(d + 6, "post_rst", 2'b11, 1'b0, 2'd0, 2'b00);
        ticks(2);

        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries pending, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
